// File: rtl/busy_ctr_dispatcher.sv
`timescale 1ns/1ps
// busy_ctr_dispatcher
// Front end for a busy counter. Tagged start requests are queued in a small
// FIFO and issued one at a time on startSignal. The counter's busy output is
// tracked, and a one-cycle done pulse carrying the finished job's tag is
// returned.
// Optional build macro: BUSY_CTR_DISPATCHER_STATS_EN adds issue and
// busy-cycle statistics outputs. Under FORMAL it also adds invariants.
module busy_ctr_dispatcher #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     req__ENA,
  output logic                     req__RDY,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     startSignal__ENA,
  input  logic                     startSignal__RDY,
  input  logic                     busy,
  input  logic                     busy__RDY,
  output logic                     done__ENA,
  output logic [TAG_W-1:0]         done_tag,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     active
`ifdef BUSY_CTR_DISPATCHER_STATS_EN
  ,
  output logic [15:0]              stat_issued,
  output logic [15:0]              stat_busy_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LP_FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

  // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of 2.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("busy_ctr_dispatcher: DEPTH must be a power of 2 and at least 2");
  end

  // IDLE  : no job outstanding; may issue the FIFO head.
  // CHECK : first cycle after issue; the counter has just loaded.
  // RUN   : counter reported busy; wait for it to drop.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [TAG_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [TAG_W-1:0]   r_cur_tag;
  logic               r_done_ena;
  logic [TAG_W-1:0]   r_done_tag;

  logic               w_not_full;
  logic               w_not_empty;
  logic               w_push;
  logic               w_issue;
  logic               w_done_set;

  // Ready and emptiness come from the registered occupancy only, so a pop in
  // the current cycle never opens space for a push in the same cycle.
  assign w_not_full  = (r_count != LP_FULL);
  assign w_not_empty = (r_count != '0);
  assign w_push      = req__ENA && w_not_full;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic, issue strobe and completion strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_not_empty && startSignal__RDY) begin
          w_issue     = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        // busy low here means a zero-length job (counter max of 1).
        if (busy__RDY) begin
          if (busy) begin
            w_state_nxt = S_RUN;
          end else begin
            w_done_set  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RUN: begin
        if (busy__RDY && !busy) begin
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FIFO occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO read/write pointers, wrapping modulo DEPTH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are meaningless once the pointers reset.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= req_tag;
    end
  end

  // Capture the tag of the job being issued.
  always_ff @(posedge CLK) begin
    if (w_issue) begin
      r_cur_tag <= r_mem[r_rd_ptr];
    end
  end

  // Registered completion pulse; the tag holds between pulses.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_done_ena <= 1'b0;
      r_done_tag <= '0;
    end else begin
      r_done_ena <= w_done_set;
      if (w_done_set) begin
        r_done_tag <= r_cur_tag;
      end
    end
  end

  assign req__RDY         = w_not_full;
  assign startSignal__ENA = w_issue;
  assign done__ENA        = r_done_ena;
  assign done_tag         = r_done_tag;
  assign pending          = r_count;
  assign active           = (r_state != S_IDLE);

`ifdef BUSY_CTR_DISPATCHER_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_busy_cycles;

  // Free-running statistics; both wrap naturally at 16 bits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_issued      <= '0;
      r_stat_busy_cycles <= '0;
    end else begin
      if (w_issue) begin
        r_stat_issued <= r_stat_issued + 16'd1;
      end
      if (active) begin
        r_stat_busy_cycles <= r_stat_busy_cycles + 16'd1;
      end
    end
  end

  assign stat_issued      = r_stat_issued;
  assign stat_busy_cycles = r_stat_busy_cycles;

`ifdef FORMAL
  // Occupancy never exceeds capacity and an issue never overlaps a live job.
  always_comb begin
    assert (pending <= LP_FULL);
    assert (!(startSignal__ENA && active));
  end
`endif
`endif

endmodule

// File: tb/tb_busy_ctr_dispatcher.sv
`timescale 1ns/1ps
// Bench for busy_ctr_dispatcher: directed scenarios followed by random
// traffic, against a job-level queue model and a busy-counter stand-in.
module tb_busy_ctr_dispatcher;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              CLK;
  logic              nRST;
  logic              req__ENA;
  logic              req__RDY;
  logic [TAG_W-1:0]  req_tag;
  logic              startSignal__ENA;
  logic              startSignal__RDY;
  logic              busy;
  logic              busy__RDY;
  logic              done__ENA;
  logic [TAG_W-1:0]  done_tag;
  logic [CNT_W-1:0]  pending;
  logic              active;
`ifdef BUSY_CTR_DISPATCHER_STATS_EN
  logic [15:0]       stat_issued;
  logic [15:0]       stat_busy_cycles;
`endif

  busy_ctr_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .req__ENA         (req__ENA),
    .req__RDY         (req__RDY),
    .req_tag          (req_tag),
    .startSignal__ENA (startSignal__ENA),
    .startSignal__RDY (startSignal__RDY),
    .busy             (busy),
    .busy__RDY        (busy__RDY),
    .done__ENA        (done__ENA),
    .done_tag         (done_tag),
    .pending          (pending),
    .active           (active)
`ifdef BUSY_CTR_DISPATCHER_STATS_EN
    ,
    .stat_issued      (stat_issued),
    .stat_busy_cycles (stat_busy_cycles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Downstream busy counter: after a start it is busy for ds_max-1 cycles.
  int   ds_max;
  int   ds_cnt;
  logic start_gate;
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) ds_cnt <= 0;
    else if (startSignal__ENA) ds_cnt <= ds_max - 1;
    else if (ds_cnt != 0) ds_cnt <= ds_cnt - 1;
  end
  assign busy             = (ds_cnt != 0);
  assign startSignal__RDY = !busy && start_gate;

  // Reference model: queue of waiting tags plus at most one job in flight.
  logic [TAG_W-1:0] m_q[$];
  logic             m_inflight;
  logic [TAG_W-1:0] m_cur;
  logic             m_done;
  logic [TAG_W-1:0] m_done_tag;
  logic [15:0]      m_issued;
  logic [15:0]      m_busycyc;
  logic             m_last_push;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic             s_req_ena;
  logic [TAG_W-1:0] s_req_tag;
  logic             s_busy_rdy;
  logic             s_gate;

  int               ev_start[$];
  int               ev_done_cyc[$];
  logic [TAG_W-1:0] ev_done_tag[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inflight  = 1'b0;
    m_done      = 1'b0;
    m_done_tag  = '0;
    m_issued    = '0;
    m_busycyc   = '0;
    m_last_push = 1'b0;
  endtask

  task automatic clear_events();
    ev_start.delete();
    ev_done_cyc.delete();
    ev_done_tag.delete();
  endtask

  // Compare every output against the model at the current instant.
  task automatic check_now(output logic e_rdy, output logic e_start);
    int e_pend;
    e_pend  = m_q.size();
    e_rdy   = (e_pend != DEPTH);
    e_start = !m_inflight && (e_pend != 0) && startSignal__RDY;
    chk("req_rdy",  32'(req__RDY),         32'(e_rdy));
    chk("start",    32'(startSignal__ENA), 32'(e_start));
    chk("done",     32'(done__ENA),        32'(m_done));
    chk("done_tag", 32'(done_tag),         32'(m_done_tag));
    chk("pending",  32'(pending),          32'(e_pend));
    chk("active",   32'(active),           32'(m_inflight));
`ifdef BUSY_CTR_DISPATCHER_STATS_EN
    chk("stat_issued", 32'(stat_issued),      32'(m_issued));
    chk("stat_busy",   32'(stat_busy_cycles), 32'(m_busycyc));
`endif
  endtask

  // One clock cycle: drive at negedge, check, then advance the model.
  task automatic step();
    logic             e_rdy, e_start, busy_v, brdy_v, push_v, was_inflight;
    logic [TAG_W-1:0] tag_v;
    @(negedge CLK);
    req__ENA   = s_req_ena;
    req_tag    = s_req_tag;
    busy__RDY  = s_busy_rdy;
    start_gate = s_gate;
    #1;
    check_now(e_rdy, e_start);
    if (startSignal__ENA === 1'b1) ev_start.push_back(cyc);
    if (done__ENA === 1'b1) begin
      ev_done_cyc.push_back(cyc);
      ev_done_tag.push_back(done_tag);
    end
    busy_v       = busy;
    brdy_v       = busy__RDY;
    push_v       = s_req_ena && e_rdy;
    tag_v        = s_req_tag;
    was_inflight = m_inflight;
    @(posedge CLK);
    m_last_push = push_v;
    if (e_start) begin
      m_cur      = m_q.pop_front();
      m_inflight = 1'b1;
      m_issued   = m_issued + 16'd1;
      m_done     = 1'b0;
    end else if (m_inflight && brdy_v && !busy_v) begin
      m_done     = 1'b1;
      m_done_tag = m_cur;
      m_inflight = 1'b0;
    end else begin
      m_done = 1'b0;
    end
    if (was_inflight) m_busycyc = m_busycyc + 16'd1;
    if (push_v) m_q.push_back(tag_v);
    cyc++;
  endtask

  // Hold a request until the FIFO takes it (bounded).
  task automatic push_tag(input logic [TAG_W-1:0] t);
    s_req_ena = 1'b1;
    s_req_tag = t;
    for (int k = 0; k < 100; k++) begin
      step();
      if (m_last_push) break;
    end
    chk("push_accepted", 32'(m_last_push), 32'(1));
    s_req_ena = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    logic e_rdy, e_start;
    #3;
    nRST     = 1'b0;
    req__ENA = 1'b0;
    s_req_ena = 1'b0;
    #1;
    model_reset();
    check_now(e_rdy, e_start);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e_rdy, e_start;
    int   base;
    logic [TAG_W-1:0] exp_tags [6];

    nRST = 1'b0; req__ENA = 1'b0; req_tag = '0; busy__RDY = 1'b0;
    start_gate = 1'b0; ds_max = 22;
    s_req_ena = 1'b0; s_req_tag = '0; s_busy_rdy = 1'b1; s_gate = 1'b1;
    model_reset();
    #7;
    check_now(e_rdy, e_start);
    @(negedge CLK);
    nRST = 1'b1;

    // Single request, tag 3, MAX_AMOUNT 22.
    clear_events();
    base = cyc;
    s_req_ena = 1'b1; s_req_tag = 4'd3;
    step();
    s_req_ena = 1'b0;
    repeat (30) step();
    chk("s1_nstart", 32'(ev_start.size()), 32'(1));
    chk("s1_ndone",  32'(ev_done_cyc.size()), 32'(1));
    if (ev_start.size() == 1) chk("s1_start_cyc", 32'(ev_start[0]), 32'(base + 1));
    if (ev_done_cyc.size() == 1) begin
      chk("s1_done_cyc", 32'(ev_done_cyc[0]), 32'(base + 24));
      chk("s1_done_tag", 32'(ev_done_tag[0]), 32'(3));
    end

    // Back-to-back tags 1..5, then tag 9 pushed against a full FIFO.
    clear_events();
    base = cyc;
    for (int t = 1; t <= 5; t++) push_tag(TAG_W'(t));
    push_tag(4'd9);
    for (int k = 0; k < 200 && ev_done_cyc.size() < 6; k++) step();
    exp_tags[0] = 4'd1; exp_tags[1] = 4'd2; exp_tags[2] = 4'd3;
    exp_tags[3] = 4'd4; exp_tags[4] = 4'd5; exp_tags[5] = 4'd9;
    chk("s2_ndone", 32'(ev_done_cyc.size()), 32'(6));
    if (ev_done_cyc.size() == 6) begin
      chk("s2_first_done", 32'(ev_done_cyc[0]), 32'(base + 24));
      for (int i = 0; i < 6; i++) begin
        chk("s2_tag_order", 32'(ev_done_tag[i]), 32'(exp_tags[i]));
        if (i > 0) chk("s2_spacing", 32'(ev_done_cyc[i] - ev_done_cyc[i-1]), 32'(23));
      end
    end

    // Zero-length job: MAX_AMOUNT 1.
    clear_events();
    ds_max = 1;
    push_tag(4'd7);
    repeat (6) step();
    chk("s4_ndone", 32'(ev_done_cyc.size()), 32'(1));
    if (ev_done_cyc.size() == 1 && ev_start.size() == 1) begin
      chk("s4_tag", 32'(ev_done_tag[0]), 32'(7));
      chk("s4_latency", 32'(ev_done_cyc[0] - ev_start[0]), 32'(2));
    end

    // Reset mid-RUN with two jobs queued.
    ds_max = 22;
    push_tag(4'd10); push_tag(4'd11); push_tag(4'd12);
    repeat (8) step();
    chk("s5_pending_before", 32'(pending), 32'(2));
    async_reset();
    clear_events();
    repeat (40) step();
    chk("s5_no_done",  32'(ev_done_cyc.size()), 32'(0));
    chk("s5_no_start", 32'(ev_start.size()), 32'(0));

`ifdef BUSY_CTR_DISPATCHER_STATS_EN
    // Two 22-cycle jobs from a clean reset.
    push_tag(4'd1); push_tag(4'd2);
    repeat (60) step();
    chk("st_issued", 32'(stat_issued), 32'(2));
    chk("st_busy",   32'(stat_busy_cycles), 32'(44));
`endif

    // Random traffic with stalls on busy__RDY and startSignal__RDY.
    for (int k = 0; k < 800; k++) begin
      s_req_ena  = ($urandom_range(0, 2) != 0);
      s_req_tag  = TAG_W'($urandom);
      s_busy_rdy = ($urandom_range(0, 9) != 0);
      s_gate     = ($urandom_range(0, 7) != 0);
      ds_max     = $urandom_range(1, 6);
      step();
    end
    s_req_ena = 1'b0; s_busy_rdy = 1'b1; s_gate = 1'b1;
    repeat (100) step();
    chk("rand_drained", 32'(pending), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/busy_ctr_dispatcher.md
Name: busy_ctr_dispatcher

Overview:
- Upstream stage for the busy-counter block.
- Buffers tagged start requests in a small FIFO and issues them one at a time on the counter's startSignal method.
- Tracks the counter's busy output and returns a completion pulse carrying the tag of the finished job.
- Sits between the request source (sequencer or CPU-side method) and the busy counter.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, minimum 2.
- TAG_W, 4, width of the request/completion tag.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; asynchronous, active-low.
- req__ENA  in  1  enqueue request; ignored unless req__RDY is high.
- req__RDY  out  1  FIFO not full.
- req_tag  in  TAG_W  tag for the request.
- startSignal__ENA  out  1  start the downstream counter.
- startSignal__RDY  in  1  downstream counter idle.
- busy  in  1  downstream counter running.
- busy__RDY  in  1  busy valid; the FSM advances only while this is high.
- done__ENA  out  1  one-cycle completion pulse.
- done_tag  out  TAG_W  tag of the completed job; valid when done__ENA is high.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.
- active  out  1  job issued and not yet completed.

Behaviour:
- Reset (async assert, sync release): FIFO empty, pending=0, state IDLE, done__ENA=0, done_tag=0, active=0, startSignal__ENA=0.
- FIFO:
  - req__RDY = (pending != DEPTH), computed from registered occupancy only.
  - Push when req__ENA && req__RDY.
  - Pop only on issue.
  - Push and pop in the same cycle: occupancy unchanged.
  - Full: a push in the same cycle as a pop is refused; no bypass.
  - Pointers wrap modulo DEPTH.
- startSignal__ENA is combinational: state==IDLE && pending!=0 && startSignal__RDY.
  - Never asserted otherwise.
  - Never asserted on the cycle a request enters an empty FIFO, so minimum request-to-start latency is 1 cycle.
- States:
  - IDLE: on issue, pop the head into cur_tag, set active=1, go to CHECK.
  - CHECK: one cycle after issue, the counter has loaded.
    - busy=1 → RUN.
    - busy=0 → zero-length job (downstream max amount of 1) → DONE path.
  - RUN: stay while busy=1. busy=0 → DONE path.
  - DONE path: next cycle done__ENA=1, done_tag=cur_tag, active=0, state=IDLE.
  - busy__RDY=0 in CHECK or RUN: hold state.
- done__ENA is registered, high for exactly one cycle per issued job, in issue order.
- In the cycle done__ENA is high the state is IDLE, so a new issue may coincide with it.
- An in-flight job never overlaps another issue: only one outstanding job.
- Reset mid-job: in-flight tag and FIFO contents are discarded; no done pulse is emitted for them.
- done_tag holds its last value when done__ENA is low.

Optional Feature:
- Macro: BUSY_CTR_DISPATCHER_STATS_EN.
- Defined:
  - Adds outputs stat_issued[15:0] and stat_busy_cycles[15:0], both reset to 0.
  - stat_issued increments on each startSignal__ENA.
  - stat_busy_cycles increments each cycle active=1.
  - Both wrap at 16'hFFFF → 0.
  - Under FORMAL, asserts pending <= DEPTH and !(startSignal__ENA && active).
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan (downstream model: busy counter with MAX_AMOUNT=22, DEPTH=4):
- Single request tag=3 at cycle 0:
  - startSignal__ENA at cycle 1.
  - active=1 from cycle 2.
  - busy high cycles 2–22.
  - done__ENA=1 with done_tag=3 at cycle 24, active=0.
- Back-to-back requests tags 1,2,3,4,5 on consecutive cycles:
  - req__RDY drops after the 4th is held with none popped beyond the first.
  - Tag 5 is accepted once space frees.
  - done tags arrive in order 1,2,3,4,5, each 23 cycles apart.
- FIFO full with a simultaneous issue and req__ENA: push refused, pending stays 3 after pop, tag not lost.
- Downstream MAX_AMOUNT=1: request tag=7 → busy never rises; CHECK sees busy=0; done__ENA with tag 7 two cycles after issue.
- nRST asserted mid-RUN with 2 queued: outputs reset immediately (asynchronous); no done pulses afterwards; pending=0.
- With BUSY_CTR_DISPATCHER_STATS_EN: 2 jobs at MAX_AMOUNT=22 → stat_issued=2, stat_busy_cycles=44.
